// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch -- instruction fetch unit front end
//
// Purpose:
//   Issues single outstanding fetch requests to instruction memory, delivers
//   fetched instructions into the IF/ID register, parks one response in a
//   hold buffer while decode is stalled, and handles redirects (branch, jump
//   or trap) including discarding a stale in-flight response.
//
// Optional feature macro:
//   IFU_MISALIGN_CHK_EN - when defined, a redirect to a PC with bits [1:0]
//   non-zero enters a FAULT state that reports an instruction-address-
//   misaligned instruction to decode and stops fetching until the next
//   redirect. When undefined, redirect PCs are word-aligned by clearing
//   bits [1:0] and if_misalign_o is tied low.
//
// Ports:
//   clk_i          in   1      clock, all state on rising edge
//   rst_i          in   1      synchronous active-high reset
//   imem_req_o     out  1      fetch request valid
//   imem_addr_o    out  XLEN   fetch address (internal pc)
//   imem_gnt_i     in   1      request accepted this cycle
//   imem_rvalid_i  in   1      response data valid
//   imem_rdata_i   in   32     fetched instruction
//   redirect_i     in   1      flush and restart at redirect_pc_i
//   redirect_pc_i  in   XLEN   new fetch PC
//   stall_i        in   1      decode cannot consume the IF/ID register
//   if_valid_o     out  1      IF/ID holds a valid instruction
//   if_pc_o        out  XLEN   PC of if_instr_o
//   if_instr_o     out  32     instruction to decode
//   if_misalign_o  out  1      instruction-address-misaligned flag
// ---------------------------------------------------------------------------
module ifu_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int          XLEN     = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            stall_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [31:0]     if_instr_o,
    output logic            if_misalign_o
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_DROP  = 3'd3
`ifdef IFU_MISALIGN_CHK_EN
        ,S_FAULT = 3'd4
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] hold_pc_q;
    logic [31:0]     hold_instr_q;
    logic            if_valid_q;
    logic [XLEN-1:0] if_pc_q;
    logic [31:0]     if_instr_q;
    logic [XLEN-1:0] redirect_target;
    logic            redirect_misaligned;
    logic            ifid_free;
    logic            resp_accept;

`ifdef IFU_MISALIGN_CHK_EN
    logic            if_misalign_q;
`endif

    // The redirect target is taken verbatim when misalignment checking is
    // enabled (the FAULT path reports the raw PC); otherwise the low two bits
    // are masked off so fetch always stays word-aligned.
    always_comb begin
        ifid_free   = !if_valid_q || !stall_i;
        resp_accept = (state_q == S_WAIT) && imem_rvalid_i;
`ifdef IFU_MISALIGN_CHK_EN
        redirect_target     = redirect_pc_i;
        redirect_misaligned = redirect_i && (redirect_pc_i[1:0] != 2'b00);
`else
        redirect_target     = redirect_pc_i & ~XLEN'(3);
        redirect_misaligned = 1'b0;
`endif
    end

    // State register: reset always returns to REQ, which drops any response
    // that was still in flight since REQ ignores rvalid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A redirect outranks everything. When a request has
    // been granted but its response has not yet arrived, the redirect goes to
    // DROP so exactly one stale response is swallowed before fetching anew.
    always_comb begin
        state_d = state_q;
        if (redirect_i) begin
            case (state_q)
                S_REQ:   state_d = imem_gnt_i    ? S_DROP : S_REQ;
                S_WAIT:  state_d = imem_rvalid_i ? S_REQ  : S_DROP;
                S_DROP:  state_d = imem_rvalid_i ? S_REQ  : S_DROP;
                default: state_d = S_REQ;
            endcase
`ifdef IFU_MISALIGN_CHK_EN
            if (redirect_misaligned) begin
                state_d = S_FAULT;
            end
`endif
        end else begin
            case (state_q)
                S_REQ:   state_d = imem_gnt_i ? S_WAIT : S_REQ;
                S_WAIT:  state_d = !imem_rvalid_i ? S_WAIT : (ifid_free ? S_REQ : S_HOLD);
                S_HOLD:  state_d = stall_i ? S_HOLD : S_REQ;
                S_DROP:  state_d = imem_rvalid_i ? S_REQ : S_DROP;
`ifdef IFU_MISALIGN_CHK_EN
                S_FAULT: state_d = S_FAULT;
`endif
                default: state_d = S_REQ;
            endcase
        end
    end

    // Outputs derived from state. The request is masked while reset is held
    // so the memory never sees a request during reset.
    always_comb begin
        imem_req_o  = (state_q == S_REQ) && !rst_i;
        imem_addr_o = pc_q;
        if_valid_o  = if_valid_q;
        if_pc_o     = if_pc_q;
        if_instr_o  = if_instr_q;
`ifdef IFU_MISALIGN_CHK_EN
        if_misalign_o = if_misalign_q;
`else
        if_misalign_o = 1'b0;
`endif
    end

    // Fetch PC and hold buffer. The PC advances only when a response is
    // accepted in WAIT, whether it lands in IF/ID or in the hold buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q         <= XLEN'(RESET_PC);
            hold_pc_q    <= '0;
            hold_instr_q <= NOP;
        end else if (redirect_i) begin
            pc_q <= redirect_target;
        end else if (resp_accept) begin
            pc_q <= pc_q + XLEN'(4);
            if (!ifid_free) begin
                hold_pc_q    <= pc_q;
                hold_instr_q <= imem_rdata_i;
            end
        end
    end

    // IF/ID register. A redirect flushes it (or, for a misaligned target,
    // loads the fault marker). Otherwise a fresh response or the hold buffer
    // loads it when decode can take it; when decode consumes without a
    // replacement the valid bit drops, and under stall everything is frozen.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= NOP;
`ifdef IFU_MISALIGN_CHK_EN
            if_misalign_q <= 1'b0;
`endif
        end else if (redirect_i) begin
            if_valid_q <= redirect_misaligned;
            if (redirect_misaligned) begin
                if_pc_q    <= redirect_pc_i;
                if_instr_q <= NOP;
            end
`ifdef IFU_MISALIGN_CHK_EN
            if_misalign_q <= redirect_misaligned;
`endif
        end else if (resp_accept && ifid_free) begin
            if_valid_q <= 1'b1;
            if_pc_q    <= pc_q;
            if_instr_q <= imem_rdata_i;
`ifdef IFU_MISALIGN_CHK_EN
            if_misalign_q <= 1'b0;
`endif
        end else if ((state_q == S_HOLD) && !stall_i) begin
            if_valid_q <= 1'b1;
            if_pc_q    <= hold_pc_q;
            if_instr_q <= hold_instr_q;
`ifdef IFU_MISALIGN_CHK_EN
            if_misalign_q <= 1'b0;
`endif
        end else if (!stall_i) begin
            if_valid_q <= 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
            if_misalign_q <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// ---------------------------------------------------------------------------
// tb_ifu_fetch -- directed self-checking bench for ifu_fetch
//
// Walks the fetch unit through reset, the basic fetch loop, stall/hold,
// redirect with a stale response, flush-over-stall, PC wrap, redirect with a
// same-cycle grant, misaligned redirect handling and reset mid-transaction.
// Inputs are driven and outputs sampled 1ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_ifu_fetch;

    localparam int XLEN = 64;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [31:0]     imem_rdata_i;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            stall_i;
    logic            if_valid_o;
    logic [XLEN-1:0] if_pc_o;
    logic [31:0]     if_instr_o;
    logic            if_misalign_o;

    int errors = 0;
    int checks = 0;

    ifu_fetch #(
        .RESET_PC (64'h0000_0000_8000_0000),
        .XLEN     (XLEN)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .stall_i       (stall_i),
        .if_valid_o    (if_valid_o),
        .if_pc_o       (if_pc_o),
        .if_instr_o    (if_instr_o),
        .if_misalign_o (if_misalign_o)
    );

    // Free-running 10ns clock.
    always #5 clk_i = ~clk_i;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        redirect_i = 1'b0; redirect_pc_i = '0; stall_i = 1'b0;
        tick(); tick();
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %0h expected 0", imem_req_o); end
        checks++; if (if_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0h expected 0", if_valid_o); end
        checks++; if (if_pc_o !== 64'h0) begin errors++; $display("[TB] FAIL reset_if_pc: got %h expected 0", if_pc_o); end
        checks++; if (if_instr_o !== 32'h0000_0013) begin errors++; $display("[TB] FAIL reset_instr: got %h expected 00000013", if_instr_o); end
        checks++; if (if_misalign_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_misalign: got %0h expected 0", if_misalign_o); end
        checks++; if (imem_addr_o !== 64'h8000_0000) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 80000000", imem_addr_o); end
        rst_i = 1'b0;
        #1;
        checks++; if (imem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL release_req: got %0h expected 1", imem_req_o); end
    endtask

    task automatic test_fetch();
        imem_gnt_i = 1'b1;
        tick();
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL fetch0_wait_req: got %0h expected 0", imem_req_o); end
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hAAAA_0001;
        checks++; if (if_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL fetch0_early_valid: got %0h expected 0", if_valid_o); end
        tick();
        imem_rvalid_i = 1'b0;
        checks++; if (if_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL fetch0_valid: got %0h expected 1", if_valid_o); end
        checks++; if (if_pc_o !== 64'h8000_0000) begin errors++; $display("[TB] FAIL fetch0_pc: got %h expected 80000000", if_pc_o); end
        checks++; if (if_instr_o !== 32'hAAAA_0001) begin errors++; $display("[TB] FAIL fetch0_instr: got %h expected aaaa0001", if_instr_o); end
        checks++; if (imem_addr_o !== 64'h8000_0004) begin errors++; $display("[TB] FAIL fetch1_addr: got %h expected 80000004", imem_addr_o); end
        checks++; if (imem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL fetch1_req: got %0h expected 1", imem_req_o); end
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        checks++; if (if_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL fetch0_consumed: got %0h expected 0", if_valid_o); end
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBBBB_0002;
        tick();
        imem_rvalid_i = 1'b0;
        checks++; if (if_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL fetch1_valid: got %0h expected 1", if_valid_o); end
        checks++; if (if_pc_o !== 64'h8000_0004) begin errors++; $display("[TB] FAIL fetch1_pc: got %h expected 80000004", if_pc_o); end
        checks++; if (if_instr_o !== 32'hBBBB_0002) begin errors++; $display("[TB] FAIL fetch1_instr: got %h expected bbbb0002", if_instr_o); end
    endtask

    task automatic test_stall_hold();
        stall_i = 1'b1; imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        checks++; if (if_instr_o !== 32'hBBBB_0002) begin errors++; $display("[TB] FAIL stall_held_instr: got %h expected bbbb0002", if_instr_o); end
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hCCCC_0003;
        tick();
        imem_rvalid_i = 1'b0;
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL hold_req: got %0h expected 0", imem_req_o); end
        checks++; if (if_pc_o !== 64'h8000_0004) begin errors++; $display("[TB] FAIL hold_if_pc: got %h expected 80000004", if_pc_o); end
        checks++; if (if_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL hold_valid: got %0h expected 1", if_valid_o); end
        tick();
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL hold2_req: got %0h expected 0", imem_req_o); end
        stall_i = 1'b0;
        tick();
        checks++; if (if_instr_o !== 32'hCCCC_0003) begin errors++; $display("[TB] FAIL unhold_instr: got %h expected cccc0003", if_instr_o); end
        checks++; if (if_pc_o !== 64'h8000_0008) begin errors++; $display("[TB] FAIL unhold_pc: got %h expected 80000008", if_pc_o); end
        checks++; if (imem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL unhold_req: got %0h expected 1", imem_req_o); end
        checks++; if (imem_addr_o !== 64'h8000_000C) begin errors++; $display("[TB] FAIL unhold_addr: got %h expected 8000000c", imem_addr_o); end
        tick();
        checks++; if (if_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL unhold_consumed: got %0h expected 0", if_valid_o); end
        checks++; if (imem_addr_o !== 64'h8000_000C) begin errors++; $display("[TB] FAIL req_addr_stable: got %h expected 8000000c", imem_addr_o); end
    endtask

    task automatic test_redirect_drop();
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 64'h8000_0100;
        tick();
        redirect_i = 1'b0;
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL drop_req: got %0h expected 0", imem_req_o); end
        checks++; if (imem_addr_o !== 64'h8000_0100) begin errors++; $display("[TB] FAIL drop_addr: got %h expected 80000100", imem_addr_o); end
        tick();
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
        tick();
        imem_rvalid_i = 1'b0;
        checks++; if (if_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL drop_stale_valid: got %0h expected 0", if_valid_o); end
        checks++; if (imem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL drop_exit_req: got %0h expected 1", imem_req_o); end
        checks++; if (imem_addr_o !== 64'h8000_0100) begin errors++; $display("[TB] FAIL drop_exit_addr: got %h expected 80000100", imem_addr_o); end
    endtask

    task automatic test_flush_over_stall();
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDDDD_0004;
        tick();
        imem_rvalid_i = 1'b0;
        checks++; if (if_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL flush_pre_valid: got %0h expected 1", if_valid_o); end
        stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 64'h8000_0200;
        tick();
        stall_i = 1'b0; redirect_i = 1'b0;
        checks++; if (if_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid: got %0h expected 0", if_valid_o); end
        checks++; if (imem_addr_o !== 64'h8000_0200) begin errors++; $display("[TB] FAIL flush_addr: got %h expected 80000200", imem_addr_o); end
        checks++; if (imem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL flush_req: got %0h expected 1", imem_req_o); end
    endtask

    task automatic test_wrap();
        redirect_i = 1'b1; redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_i = 1'b0; imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hEEEE_0005;
        tick();
        imem_rvalid_i = 1'b0;
        checks++; if (if_pc_o !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_if_pc: got %h expected fffffffffffffffc", if_pc_o); end
        checks++; if (imem_addr_o !== 64'h0) begin errors++; $display("[TB] FAIL wrap_addr: got %h expected 0", imem_addr_o); end
    endtask

    task automatic test_redirect_gnt();
        imem_gnt_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 64'h8000_0300;
        tick();
        imem_gnt_i = 1'b0; redirect_i = 1'b0;
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL gntdrop_req: got %0h expected 0", imem_req_o); end
        checks++; if (if_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL gntdrop_valid: got %0h expected 0", if_valid_o); end
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_0006;
        tick();
        imem_rvalid_i = 1'b0;
        checks++; if (if_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL gntdrop_stale: got %0h expected 0", if_valid_o); end
        checks++; if (imem_addr_o !== 64'h8000_0300) begin errors++; $display("[TB] FAIL gntdrop_addr: got %h expected 80000300", imem_addr_o); end
        checks++; if (imem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL gntdrop_exit_req: got %0h expected 1", imem_req_o); end
    endtask

    task automatic test_misalign();
        redirect_i = 1'b1; redirect_pc_i = 64'h8000_0102;
        tick();
        redirect_i = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
        checks++; if (if_misalign_o !== 1'b1) begin errors++; $display("[TB] FAIL fault_misalign: got %0h expected 1", if_misalign_o); end
        checks++; if (if_pc_o !== 64'h8000_0102) begin errors++; $display("[TB] FAIL fault_pc: got %h expected 80000102", if_pc_o); end
        checks++; if (if_instr_o !== 32'h0000_0013) begin errors++; $display("[TB] FAIL fault_instr: got %h expected 00000013", if_instr_o); end
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL fault_req: got %0h expected 0", imem_req_o); end
        tick(); tick();
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL fault_req_later: got %0h expected 0", imem_req_o); end
        redirect_i = 1'b1; redirect_pc_i = 64'h8000_0200;
        tick();
        redirect_i = 1'b0;
        checks++; if (imem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL fault_exit_req: got %0h expected 1", imem_req_o); end
        checks++; if (imem_addr_o !== 64'h8000_0200) begin errors++; $display("[TB] FAIL fault_exit_addr: got %h expected 80000200", imem_addr_o); end
`else
        checks++; if (imem_addr_o !== 64'h8000_0100) begin errors++; $display("[TB] FAIL align_addr: got %h expected 80000100", imem_addr_o); end
        checks++; if (if_misalign_o !== 1'b0) begin errors++; $display("[TB] FAIL align_misalign: got %0h expected 0", if_misalign_o); end
        checks++; if (imem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL align_req: got %0h expected 1", imem_req_o); end
`endif
    endtask

    task automatic test_reset_mid();
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0; rst_i = 1'b1;
        tick();
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_req: got %0h expected 0", imem_req_o); end
        checks++; if (imem_addr_o !== 64'h8000_0000) begin errors++; $display("[TB] FAIL midrst_addr: got %h expected 80000000", imem_addr_o); end
        checks++; if (if_pc_o !== 64'h0) begin errors++; $display("[TB] FAIL midrst_if_pc: got %h expected 0", if_pc_o); end
        rst_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0123_4567;
        #1;
        checks++; if (imem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL midrst_release_req: got %0h expected 1", imem_req_o); end
        tick();
        imem_rvalid_i = 1'b0;
        checks++; if (if_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_stale: got %0h expected 0", if_valid_o); end
        checks++; if (imem_addr_o !== 64'h8000_0000) begin errors++; $display("[TB] FAIL midrst_addr2: got %h expected 80000000", imem_addr_o); end
    endtask

    // Scenario sequence; each task leaves the unit in a known state for the next.
    initial begin
        test_reset();
        test_fetch();
        test_stall_hold();
        test_redirect_drop();
        test_flush_over_stall();
        test_wrap();
        test_redirect_gnt();
        test_misalign();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
